// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU result checker.
// Build option: ALU_CHK_OPHIST_EN adds per-opcode mismatch counters.
package alu_chk_pkg;

    localparam int OP_W   = 3;
    localparam int OPND_W = 4;
    localparam int PAT_W  = OP_W + 2 * OPND_W;

    localparam int DEF_CNT_W   = 12;
    localparam int DEF_RW      = 8;
    localparam int DEF_PAT_NUM = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/alu_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module alu_chk_sat_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // clear wins over increment; increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/alu_result_checker.sv
// On-board scoreboard for the 4-bit ALU: 2-stage compare, pattern/error
// counting, first-fail capture and done/pass after PAT_NUM patterns.
// Build option: ALU_CHK_OPHIST_EN adds err_op_cnt (8 per-opcode counters).
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | after reset, waiting for start
// ST_RUN  | accepting triples until PAT_NUM compares retire
// ST_DONE | results held, waiting for start
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int PAT_NUM = DEF_PAT_NUM,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RW      = DEF_RW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [RW-1:0]     alu_c,
    input  logic [RW-1:0]     exp_c,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              fail_valid,
    output logic [PAT_W-1:0]  fail_pat,
    output logic [RW-1:0]     fail_exp,
    output logic [RW-1:0]     fail_got
`ifdef ALU_CHK_OPHIST_EN
    ,
    output logic [8*CNT_W-1:0] err_op_cnt
`endif
);

    localparam logic [CNT_W-1:0] PAT_TGT = CNT_W'(PAT_NUM);

    chk_state_e       state, state_nxt;
    logic             run_start;
    logic             accept;
    logic [CNT_W-1:0] acc_cnt;
    logic             s1_valid;
    logic [PAT_W-1:0] s1_pat;
    logic [RW-1:0]    s1_alu;
    logic [RW-1:0]    s1_exp;
    logic             s1_mis;
    logic             last_retire;

    assign in_ready    = (state == ST_RUN) && (acc_cnt < PAT_TGT);
    assign accept      = in_valid && in_ready;
    assign s1_mis      = s1_valid && (s1_alu != s1_exp);
    assign last_retire = s1_valid && (pat_cnt == PAT_TGT - CNT_W'(1));
    assign busy        = (state == ST_RUN);
    assign done        = (state == ST_DONE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state; start only matters outside RUN
    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    run_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_retire) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // stage 1: register the accepted triple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pat   <= '0;
            s1_alu   <= '0;
            s1_exp   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_pat <= {in_op, in_a, in_b};
                s1_alu <= alu_c;
                s1_exp <= exp_c;
            end
        end
    end

    // accepted and retired pattern counts; both bounded by PAT_NUM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            pat_cnt <= '0;
        end else if (run_start) begin
            acc_cnt <= '0;
            pat_cnt <= '0;
        end else begin
            if (accept)   acc_cnt <= acc_cnt + CNT_W'(1);
            if (s1_valid) pat_cnt <= pat_cnt + CNT_W'(1);
        end
    end

    // pass is decided as the final compare retires, including that compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pass <= 1'b0;
        else if (run_start)   pass <= 1'b0;
        else if (last_retire) pass <= (err_cnt == '0) && !s1_mis;
    end

    // first-fail capture; later mismatches leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid <= 1'b0;
            fail_pat   <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (run_start) begin
            fail_valid <= 1'b0;
            fail_pat   <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (s1_mis && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_pat   <= s1_pat;
            fail_exp   <= s1_exp;
            fail_got   <= s1_alu;
        end
    end

    alu_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (s1_mis),
        .cnt   (err_cnt)
    );

`ifdef ALU_CHK_OPHIST_EN
    for (genvar k = 0; k < 8; k++) begin : g_op_hist
        alu_chk_sat_cnt #(.W(CNT_W)) u_op_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (run_start),
            .inc   (s1_mis && (s1_pat[PAT_W-1 -: OP_W] == OP_W'(k))),
            .cnt   (err_op_cnt[k*CNT_W +: CNT_W])
        );
    end
`endif

endmodule
